// File: rtl/ysyx_22040125_lsu_mem_if.sv
// Request, data-RAM and response signals of the LSU memory endpoint.
// The slave modport is the LSU view; master is the surrounding pipeline/RAM view.
interface ysyx_22040125_lsu_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_ack, mem_rdata,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_ack, mem_rdata,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/ysyx_22040125_lsu_mem.sv
// LSU memory endpoint: one request -> 64-bit data-RAM transaction -> extended result.
// Optional MISALIGN_TRAP_EN: reject non-size-aligned offsets with rsp_err, skipping the bus.
module ysyx_22040125_lsu_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                    clk,
  input logic                    rst_n,
  ysyx_22040125_lsu_mem_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wmask_q, mem_wmask_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [2:0]  off_q, off_d;

  logic [2:0]  req_off;
  logic [7:0]  req_mask;
  logic        trap;
  logic [63:0] shifted;
  logic [63:0] load_data;

  // Offset rounded down to the access size; surplus low bits are ignored.
  always_comb begin
    req_off  = 3'b000;
    req_mask = 8'hFF;
    case (bus.req_size)
      2'b00: begin
        req_off  = bus.req_addr[2:0];
        req_mask = 8'h01 << req_off;
      end
      2'b01: begin
        req_off  = {bus.req_addr[2:1], 1'b0};
        req_mask = 8'h03 << req_off;
      end
      2'b10: begin
        req_off  = {bus.req_addr[2], 2'b00};
        req_mask = 8'h0F << req_off;
      end
      default: begin
        req_off  = 3'b000;
        req_mask = 8'hFF;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = (req_off != bus.req_addr[2:0]);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    shifted   = bus.mem_rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (size_q)
      2'b00:   load_data = uns_q ? {56'd0, shifted[7:0]}
                                 : {{56{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = uns_q ? {48'd0, shifted[15:0]}
                                 : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_data = uns_q ? {32'd0, shifted[31:0]}
                                 : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  // Every output is the registered copy of its *_d value, so next-state logic
  // also computes next output values.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_ready_d = 1'b0;
          mem_we_d    = bus.req_we;
          mem_addr_d  = {bus.req_addr[31:3], 3'b000};
          mem_wmask_d = req_mask;
          mem_wdata_d = bus.req_wdata;
          size_d      = bus.req_size;
          uns_d       = bus.req_unsigned;
          off_d       = req_off;
          cnt_d       = '0;
          if (trap) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = BUS;
            mem_req_d = 1'b1;
          end
        end
      end

      BUS: begin
        cnt_d = cnt_q + 8'd1;
        // Ack is tested first so it wins over a simultaneous timeout.
        if (bus.mem_ack) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_we_q ? '0 : load_data;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_22040125_lsu_mem.sv
// Randomized + directed bench for ysyx_22040125_lsu_mem against a transaction-level model.
module tb_ysyx_22040125_lsu_mem;
  localparam int unsigned TO = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ysyx_22040125_lsu_mem_if bus ();

  ysyx_22040125_lsu_mem #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected behaviour for the current cycle, set by the driver.
  int          phase = -1;  // 0 idle, 1 bus, 2 response, -1 unchecked
  logic        chk_en = 1'b0;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [7:0]  exp_mask;
  logic [63:0] exp_wdata;
  logic [63:0] exp_data;
  logic        exp_err;
  int          exp_bus_len;

  // Last values seen on the DUT, for literal checks of directed cases.
  logic [31:0] last_addr;
  logic [7:0]  last_mask;
  logic        last_we;
  logic [63:0] last_wdata;
  logic [63:0] last_rsp;
  logic        last_err;
  int          last_bus_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned nbytes_of(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic int unsigned base_of(input logic [31:0] a, input logic [1:0] sz);
    int unsigned o = a[2:0];
    int unsigned n = nbytes_of(sz);
    return (o / n) * n;
  endfunction

  function automatic logic [7:0] model_mask(input logic [31:0] a, input logic [1:0] sz);
    logic [7:0] m = '0;
    int unsigned b = base_of(a, sz);
    int unsigned n = nbytes_of(sz);
    for (int i = 0; i < 8; i++)
      if (i >= b && i < b + n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
    logic [63:0] v = '0;
    int unsigned b = base_of(a, sz);
    int unsigned n = nbytes_of(sz);
    for (int i = 0; i < n; i++) v[i*8 +: 8] = rd[(b+i)*8 +: 8];
    if (!uns && v[n*8-1])
      for (int i = n; i < 8; i++) v[i*8 +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic model_trap(input logic [31:0] a, input logic [1:0] sz);
`ifdef MISALIGN_TRAP_EN
    return (a[2:0] % nbytes_of(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  initial begin : compare
    int run = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        case (phase)
          0: begin
            chk("idle_req_ready", bus.req_ready, 1);
            chk("idle_mem_req", bus.mem_req, 0);
            chk("idle_rsp_valid", bus.rsp_valid, 0);
          end
          1: begin
            chk("bus_req_ready", bus.req_ready, 0);
            chk("bus_mem_req", bus.mem_req, 1);
            chk("bus_mem_we", bus.mem_we, exp_we);
            chk("bus_mem_addr", bus.mem_addr, exp_addr);
            chk("bus_mem_wmask", bus.mem_wmask, exp_mask);
            chk("bus_mem_wdata", bus.mem_wdata, exp_wdata);
            last_addr  = bus.mem_addr;
            last_mask  = bus.mem_wmask;
            last_we    = bus.mem_we;
            last_wdata = bus.mem_wdata;
          end
          2: begin
            chk("resp_req_ready", bus.req_ready, 0);
            chk("resp_mem_req", bus.mem_req, 0);
            chk("resp_rsp_valid", bus.rsp_valid, 1);
            chk("resp_rsp_data", bus.rsp_data, exp_data);
            chk("resp_rsp_err", bus.rsp_err, exp_err);
            last_rsp = bus.rsp_data;
            last_err = bus.rsp_err;
          end
          default: ;
        endcase
        if (bus.mem_req) run++;
        else if (run != 0) begin
          chk("bus_len", run, exp_bus_len);
          last_bus_len = run;
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
  end

  task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input int unsigned ack_delay,
                        input int unsigned stall);
    logic acked = 1'b0;
    last_mask = '0; last_addr = '0; last_we = 1'b0; last_wdata = '0;
    last_rsp = 64'hDEAD_DEAD_DEAD_DEAD; last_err = 1'b0; last_bus_len = 0;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    exp_we    = we;
    exp_addr  = {addr[31:3], 3'b000};
    exp_mask  = model_mask(addr, sz);
    exp_wdata = wdata;
    phase = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_size  = 2'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = {$urandom, $urandom};
    if (model_trap(addr, sz)) begin
      exp_data = '0;
      exp_err  = 1'b1;
      phase    = 2;
    end else begin
      exp_bus_len = (ack_delay <= TO) ? int'(ack_delay) : int'(TO);
      phase = 1;
      for (int k = 1; k <= TO; k++) begin
        bus.mem_ack   = (k == ack_delay);
        bus.mem_rdata = (k == ack_delay) ? rdata : {$urandom, $urandom};
        @(posedge clk); #1;
        if (k == ack_delay) begin
          acked = 1'b1;
          break;
        end
      end
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = {$urandom, $urandom};
      exp_err  = !acked;
      exp_data = (!acked || we) ? 64'd0 : model_load(rdata, addr, sz, uns);
      phase = 2;
    end
    for (int s = 0; s <= int'(stall); s++) begin
      bus.rsp_ready = (s == int'(stall));
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    phase = 0;
  endtask

  initial begin : driver
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wmask", bus.mem_wmask, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    phase = 0;
    chk_en = 1'b1;

    // Signed byte load
    do_txn(1'b0, 2'b00, 1'b0, 32'h8000_0005, 64'h0, 64'h0000_8000_0000_0000, 1, 0);
    chk("lb_addr", last_addr, 32'h8000_0000);
    chk("lb_mask", last_mask, 8'h20);
    chk("lb_data", last_rsp, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_err", last_err, 0);

    // Unsigned half load
    do_txn(1'b0, 2'b01, 1'b1, 32'h8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 2, 1);
    chk("lhu_data", last_rsp, 64'h0000_0000_0000_BEEF);

    // Word store
    do_txn(1'b1, 2'b10, 1'b0, 32'h8000_0004, 64'h1234_5678_1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    chk("sw_we", last_we, 1);
    chk("sw_mask", last_mask, 8'hF0);
    chk("sw_wdata", last_wdata, 64'h1234_5678_1234_5678);
    chk("sw_data", last_rsp, 0);

    // Slow ack and slow writeback
    do_txn(1'b0, 2'b11, 1'b0, 32'h8000_0008, 64'h0, 64'h8123_4567_89AB_CDEF, 10, 3);
    chk("slow_bus_len", last_bus_len, 10);
    chk("slow_data", last_rsp, 64'h8123_4567_89AB_CDEF);

    // Timeout, and ack landing on the final timeout cycle
    do_txn(1'b0, 2'b10, 1'b0, 32'h8000_0010, 64'h0, 64'h1, TO + 5, 0);
    chk("to_bus_len", last_bus_len, TO);
    chk("to_err", last_err, 1);
    chk("to_data", last_rsp, 0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h8000_0010, 64'h0, 64'h0000_0000_8000_0001, TO, 0);
    chk("ack_at_to_err", last_err, 0);
    chk("ack_at_to_data", last_rsp, 64'hFFFF_FFFF_8000_0001);

    // Misaligned word load
    do_txn(1'b0, 2'b10, 1'b1, 32'h8000_0002, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_err", last_err, 1);
    chk("mis_no_bus", last_bus_len, 0);
`else
    chk("mis_mask", last_mask, 8'h0F);
    chk("mis_err", last_err, 0);
    chk("mis_data", last_rsp, 64'h0000_0000_CCCC_DDDD);
`endif

    for (int t = 0; t < 200; t++) begin
      int unsigned dly;
      int unsigned pick = $urandom_range(0, 9);
      if (pick < 7) dly = $urandom_range(1, 4);
      else dly = $urandom_range(TO - 1, TO + 2);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      do_txn(1'($urandom), 2'($urandom), 1'($urandom), 32'h8000_0000 | ($urandom & 32'hFFFF),
             {$urandom, $urandom}, {$urandom, $urandom}, dly, $urandom_range(0, 3));
    end

    // Reset in the middle of a bus transaction
    chk_en = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b11; bus.req_addr = 32'h8000_0020;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_mem_req", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", bus.mem_req, 0);
    chk("mid_rst_req_ready", bus.req_ready, 1);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    phase = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_txn(1'b0, 2'b00, 1'b1, 32'h8000_0023, 64'h0, 64'h0000_0000_9900_0000, 2, 0);
    chk("post_rst_data", last_rsp, 64'h99);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
